// File: rtl/huffman_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : huffman_decoder
//  Description : Bit-serial canonical Huffman decoder. The host loads the
//                per-length code counts and the canonically ordered symbol
//                list, then streams code bits MSB-first; one symbol is
//                emitted per completed codeword over a valid/ready handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module huffman_decoder #(
    parameter int SYM_W   = 8,
    parameter int MAX_LEN = 16,
    parameter int CNT_W   = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_we,
    input  logic [4:0]       cnt_addr,
    input  logic [CNT_W-1:0] cnt_data,
    input  logic             sym_we,
    input  logic [SYM_W-1:0] sym_addr,
    input  logic [SYM_W-1:0] sym_data,
    input  logic             cfg_done,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             err
);

    // Accumulators carry one guard bit above the longest code length
    localparam int c_ACC_W = MAX_LEN + 1;
    localparam int c_DEPTH = 2 ** SYM_W;

    localparam logic [1:0] c_ST_LOAD   = 2'd0;
    localparam logic [1:0] c_ST_DECODE = 2'd1;
    localparam logic [1:0] c_ST_EMIT   = 2'd2;
    localparam logic [1:0] c_ST_ERR    = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [4:0]         r_len;
    logic [c_ACC_W-1:0] r_code;
    logic [c_ACC_W-1:0] r_first;
    logic [SYM_W:0]     r_index;
    logic [CNT_W-1:0]   r_cnt [0:MAX_LEN];
    logic [SYM_W-1:0]   r_sym [0:c_DEPTH-1];
    logic [SYM_W-1:0]   r_sym_out;
    logic               r_sym_valid;

    logic               w_load;
    logic               w_bit_take;
    logic               w_emit_done;
    logic [c_ACC_W-1:0] w_c;
    logic [c_ACC_W-1:0] w_n;
    logic [c_ACC_W-1:0] w_diff;
    logic               w_hit;
    logic               w_last;
    logic [SYM_W-1:0]   w_sym_addr;

    assign w_load      = (r_state == c_ST_LOAD);
    assign w_bit_take  = (r_state == c_ST_DECODE) && bit_valid;
    assign w_emit_done = (r_state == c_ST_EMIT) && r_sym_valid && sym_ready;

    // Canonical step: code c of length L matches when c - first(L) < count(L)
    assign w_c        = r_code | {{(c_ACC_W-1){1'b0}}, bit_in};
    assign w_n        = c_ACC_W'(r_cnt[r_len]);
    assign w_diff     = w_c - r_first;
    assign w_hit      = (w_diff < w_n);
    assign w_last     = (r_len == 5'(MAX_LEN));
    assign w_sym_addr = r_index[SYM_W-1:0] + w_diff[SYM_W-1:0];

    assign bit_ready = (r_state == c_ST_DECODE);
    assign err       = (r_state == c_ST_ERR);
    assign sym_out   = r_sym_out;
    assign sym_valid = r_sym_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_LOAD: begin
                if (cfg_done) w_state_nxt = c_ST_DECODE;
            end
            c_ST_DECODE: begin
                if (bit_valid) begin
                    if (w_hit)       w_state_nxt = c_ST_EMIT;
                    else if (w_last) w_state_nxt = c_ST_ERR;
                end
            end
            c_ST_EMIT: begin
                if (w_emit_done) w_state_nxt = c_ST_DECODE;
            end
            c_ST_ERR: begin
                w_state_nxt = c_ST_ERR;
            end
            default: begin
                w_state_nxt = c_ST_LOAD;
            end
        endcase
    end

    // Codeword accumulators and the registered output symbol
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= 5'd1;
            r_code      <= '0;
            r_first     <= '0;
            r_index     <= '0;
            r_sym_out   <= '0;
            r_sym_valid <= 1'b0;
        end else if (w_load || w_emit_done) begin
            r_len       <= 5'd1;
            r_code      <= '0;
            r_first     <= '0;
            r_index     <= '0;
            r_sym_valid <= 1'b0;
        end else if (w_bit_take) begin
            if (w_hit) begin
                r_sym_out   <= r_sym[w_sym_addr];
                r_sym_valid <= 1'b1;
            end else begin
                r_index <= r_index + w_n[SYM_W:0];
                r_first <= (r_first + w_n) << 1;
                r_code  <= w_c << 1;
                r_len   <= r_len + 5'd1;
            end
        end
    end

    // Per-length count table; cleared on reset so unloaded lengths never match
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MAX_LEN; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_load && cnt_we && (cnt_addr != 5'd0) &&
                     (cnt_addr <= 5'(MAX_LEN))) begin
            r_cnt[cnt_addr] <= cnt_data;
        end
    end

    // Symbol table, canonical order, writable only while loading
    always_ff @(posedge clk) begin
        if (w_load && sym_we) begin
            r_sym[sym_addr] <= sym_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_huffman_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_huffman_decoder
//  Description : Self-checking bench for huffman_decoder. Directed cases plus
//                randomized tables/streams checked against a canonical-code
//                reference model built from explicit codeword lists.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_huffman_decoder;

    localparam int SYM_W   = 8;
    localparam int MAX_LEN = 16;
    localparam int CNT_W   = 9;

    logic             clk = 1'b0;
    logic             rst;
    logic             cnt_we;
    logic [4:0]       cnt_addr;
    logic [CNT_W-1:0] cnt_data;
    logic             sym_we;
    logic [SYM_W-1:0] sym_addr;
    logic [SYM_W-1:0] sym_data;
    logic             cfg_done;
    logic             bit_in;
    logic             bit_valid;
    logic             bit_ready;
    logic [SYM_W-1:0] sym_out;
    logic             sym_valid;
    logic             sym_ready;
    logic             err;

    int checks = 0;
    int errors = 0;

    logic [7:0] got [$];

    // Reference model state
    int m_cnt [1:16];
    int m_sym [256];
    int m_code_val [256];
    int m_code_len [256];
    int m_total;
    bit m_bits [$];
    int m_exp [$];
    bit m_err;

    always #5 clk = ~clk;

    huffman_decoder #(
        .SYM_W  (SYM_W),
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_we   (cnt_we),
        .cnt_addr (cnt_addr),
        .cnt_data (cnt_data),
        .sym_we   (sym_we),
        .sym_addr (sym_addr),
        .sym_data (sym_data),
        .cfg_done (cfg_done),
        .bit_in   (bit_in),
        .bit_valid(bit_valid),
        .bit_ready(bit_ready),
        .sym_out  (sym_out),
        .sym_valid(sym_valid),
        .sym_ready(sym_ready),
        .err      (err)
    );

    // Record every completed output handshake
    always @(negedge clk) begin
        if (!rst && sym_valid && sym_ready) got.push_back(sym_out);
    end

    // Watchdog
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Assign canonical codewords: consecutive values per length, shift between lengths
    function automatic void build_codes();
        int code;
        int k;
        code = 0;
        k = 0;
        for (int len = 1; len <= 16; len++) begin
            for (int j = 0; j < m_cnt[len]; j++) begin
                m_code_val[k] = code;
                m_code_len[k] = len;
                code++;
                k++;
            end
            code = code * 2;
        end
        m_total = k;
    endfunction

    // Prefix-match the bit stream against the explicit codeword list
    function automatic void model_run();
        int acc;
        int len;
        bit found;
        acc = 0;
        len = 0;
        m_exp.delete();
        m_err = 1'b0;
        foreach (m_bits[i]) begin
            if (!m_err) begin
                acc = acc * 2 + int'(m_bits[i]);
                len++;
                found = 1'b0;
                for (int k = 0; k < m_total; k++) begin
                    if (!found && m_code_len[k] == len && m_code_val[k] == acc) begin
                        m_exp.push_back(m_sym[k]);
                        found = 1'b1;
                    end
                end
                if (found) begin
                    acc = 0;
                    len = 0;
                end else if (len == MAX_LEN) begin
                    m_err = 1'b1;
                end
            end
        end
    endfunction

    function automatic void clear_table();
        for (int l = 1; l <= 16; l++) m_cnt[l] = 0;
        for (int k = 0; k < 256; k++) m_sym[k] = 0;
    endfunction

    function automatic void set_t1_table();
        clear_table();
        m_cnt[1] = 1;
        m_cnt[2] = 1;
        m_cnt[3] = 2;
        m_sym[0] = 8'h41;
        m_sym[1] = 8'h42;
        m_sym[2] = 8'h43;
        m_sym[3] = 8'h44;
        build_codes();
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        cnt_we    = 1'b0;
        cnt_addr  = '0;
        cnt_data  = '0;
        sym_we    = 1'b0;
        sym_addr  = '0;
        sym_data  = '0;
        cfg_done  = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        sym_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        got.delete();
    endtask

    task automatic load_table();
        for (int l = 1; l <= 16; l++) begin
            cnt_we   = 1'b1;
            cnt_addr = 5'(l);
            cnt_data = CNT_W'(m_cnt[l]);
            step();
        end
        cnt_we = 1'b0;
        for (int k = 0; k < m_total; k++) begin
            sym_we   = 1'b1;
            sym_addr = 8'(k);
            sym_data = 8'(m_sym[k]);
            step();
        end
        sym_we   = 1'b0;
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        int k;
        k = 0;
        bit_in    = b;
        bit_valid = 1'b1;
        while (!bit_ready && k < 50) begin
            step();
            k++;
        end
        chk("bit_accept_timeout", 32'(k < 50), 32'd1);
        step();
        bit_valid = 1'b0;
    endtask

    task automatic send_stream_gaps();
        foreach (m_bits[i]) begin
            repeat ($urandom_range(0, 2)) step();
            send_bit(m_bits[i]);
        end
    endtask

    task automatic compare_run(input string tag);
        logic [31:0] obs;
        repeat (4) step();
        chk($sformatf("%s_count", tag), 32'(got.size()), 32'(m_exp.size()));
        foreach (m_exp[i]) begin
            obs = (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx;
            chk($sformatf("%s_sym%0d", tag, i), obs, 32'(m_exp[i]));
        end
        chk($sformatf("%s_err", tag), 32'(err), 32'(m_err));
        got.delete();
    endtask

    initial begin
        int free;
        int maxc;
        int c;
        int k;

        do_reset();

        // Reset state
        chk("rst_bit_ready", 32'(bit_ready), 32'd0);
        chk("rst_sym_valid", 32'(sym_valid), 32'd0);
        chk("rst_sym_out",   32'(sym_out),   32'd0);
        chk("rst_err",       32'(err),       32'd0);

        // T1: four symbols of lengths 1,2,3,3
        set_t1_table();
        load_table();
        chk("t1_bit_ready", 32'(bit_ready), 32'd1);
        m_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        model_run();
        send_bit(1'b0);
        chk("t1_lat_valid", 32'(sym_valid), 32'd1);
        chk("t1_lat_ready", 32'(bit_ready), 32'd0);
        chk("t1_lat_sym",   32'(sym_out),   32'h41);
        for (int i = 1; i < 9; i++) send_bit(m_bits[i]);
        compare_run("t1");

        // T2: backpressure holds the symbol stable
        sym_ready = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_valid", 32'(sym_valid), 32'd1);
            chk("t2_hold_sym",   32'(sym_out),   32'h43);
            chk("t2_hold_ready", 32'(bit_ready), 32'd0);
            step();
        end
        sym_ready = 1'b1;
        send_bit(1'b0);
        m_bits = '{1'b1, 1'b1, 1'b0, 1'b0};
        model_run();
        compare_run("t2");

        // T6: idle cycles inside a codeword
        send_bit(1'b1);
        chk("t6_idle_ready", 32'(bit_ready), 32'd1);
        step();
        step();
        chk("t6_idle_valid", 32'(sym_valid), 32'd0);
        send_bit(1'b0);
        m_bits = '{1'b1, 1'b0};
        model_run();
        compare_run("t6");

        // T5: table writes outside LOAD are ignored
        cnt_we   = 1'b1;
        cnt_addr = 5'd1;
        cnt_data = '0;
        sym_we   = 1'b1;
        sym_addr = 8'd0;
        sym_data = 8'h00;
        step();
        cnt_we = 1'b0;
        sym_we = 1'b0;
        send_bit(1'b0);
        m_bits = '{1'b0};
        model_run();
        compare_run("t5");

        // T3: no match within MAX_LEN bits
        do_reset();
        clear_table();
        m_cnt[1] = 1;
        m_sym[0] = 8'h7F;
        build_codes();
        load_table();
        m_bits.delete();
        for (int i = 0; i < 15; i++) begin
            send_bit(1'b1);
            m_bits.push_back(1'b1);
        end
        chk("t3_err_pre",   32'(err),       32'd0);
        chk("t3_ready_pre", 32'(bit_ready), 32'd1);
        send_bit(1'b1);
        m_bits.push_back(1'b1);
        chk("t3_err",       32'(err),       32'd1);
        chk("t3_ready",     32'(bit_ready), 32'd0);
        chk("t3_valid",     32'(sym_valid), 32'd0);
        model_run();
        compare_run("t3");
        chk("t3_err_sticky", 32'(err), 32'd1);

        // T4: reset mid-codeword returns to LOAD with an empty count table
        do_reset();
        set_t1_table();
        load_table();
        send_bit(1'b1);
        send_bit(1'b1);
        rst = 1'b1;
        step();
        chk("t4_ready", 32'(bit_ready), 32'd0);
        chk("t4_err",   32'(err),       32'd0);
        chk("t4_valid", 32'(sym_valid), 32'd0);
        chk("t4_sym",   32'(sym_out),   32'd0);
        rst = 1'b0;
        step();
        chk("t4_no_sym", 32'(got.size()), 32'd0);
        cfg_done = 1'b1;
        step();
        cfg_done = 1'b0;
        clear_table();
        build_codes();
        m_bits.delete();
        for (int i = 0; i < 16; i++) m_bits.push_back(1'b0);
        foreach (m_bits[i]) send_bit(m_bits[i]);
        model_run();
        compare_run("t4");

        // Randomized tables and codeword streams
        for (int it = 0; it < 6; it++) begin
            do_reset();
            clear_table();
            free = 2;
            m_total = 0;
            for (int l = 1; l <= 16; l++) begin
                maxc = free;
                if (maxc > 256 - m_total) maxc = 256 - m_total;
                if (maxc > 6) maxc = 6;
                c = int'($urandom_range(0, maxc));
                m_cnt[l] = c;
                m_total += c;
                free = (free - c) * 2;
            end
            if (m_total == 0) m_cnt[16] = 1;
            build_codes();
            for (int s = 0; s < m_total; s++) m_sym[s] = int'($urandom_range(0, 255));
            load_table();
            m_bits.delete();
            repeat (12) begin
                k = int'($urandom_range(0, m_total - 1));
                for (int b = m_code_len[k] - 1; b >= 0; b--) begin
                    m_bits.push_back(bit'((m_code_val[k] >> b) & 1));
                end
            end
            model_run();
            send_stream_gaps();
            compare_run($sformatf("rnd%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
